// File: rtl/uart_frame_parser.sv
// Assembles UART bytes into 0x55 0xAA CMD LEN PAYLOAD CSUM frames, checks length and
// checksum, enforces an inter-byte timeout and publishes each good frame with a valid pulse.
module uart_frame_parser #(
   parameter int          MAX_LEN     = 8,
   parameter int          TIMEOUT_CYC = 200000,
   parameter logic [7:0]  HDR0        = 8'h55,
   parameter logic [7:0]  HDR1        = 8'hAA
) (
   input  logic                   sys_clk,
   input  logic                   rst,
   input  logic [7:0]             rx_data,
   input  logic                   rx_done,
   output logic                   frame_valid,
   output logic [7:0]             frame_cmd,
   output logic [3:0]             frame_len,
   output logic [MAX_LEN*8-1:0]   frame_payload,
   output logic                   csum_err,
   output logic                   len_err,
   output logic                   timeout_err
);

   localparam int PW    = MAX_LEN * 8;
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]       LEN_MAX  = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_HDR0 = 3'd0,
      S_HDR1 = 3'd1,
      S_CMD  = 3'd2,
      S_LEN  = 3'd3,
      S_PAY  = 3'd4,
      S_CSUM = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [3:0]       len_q, len_d;
   logic [7:0]       sum_q, sum_d;
   logic [3:0]       idx_q, idx_d;
   logic [PW-1:0]    shadow_q, shadow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_valid_q, frame_valid_d;
   logic [7:0]       frame_cmd_q, frame_cmd_d;
   logic [3:0]       frame_len_q, frame_len_d;
   logic [PW-1:0]    frame_payload_q, frame_payload_d;
   logic             csum_err_q, csum_err_d;
   logic             len_err_q, len_err_d;
   logic             timeout_err_q, timeout_err_d;
   logic             tmo_hit;

   // A byte arriving on the terminal-count cycle suppresses the timeout.
   assign tmo_hit = (state_q != S_HDR0) && !rx_done && (cnt_q == CNT_LAST);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_HDR0;
         cmd_q           <= '0;
         len_q           <= '0;
         sum_q           <= '0;
         idx_q           <= '0;
         shadow_q        <= '0;
         cnt_q           <= '0;
         frame_valid_q   <= 1'b0;
         frame_cmd_q     <= '0;
         frame_len_q     <= '0;
         frame_payload_q <= '0;
         csum_err_q      <= 1'b0;
         len_err_q       <= 1'b0;
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         cmd_q           <= cmd_d;
         len_q           <= len_d;
         sum_q           <= sum_d;
         idx_q           <= idx_d;
         shadow_q        <= shadow_d;
         cnt_q           <= cnt_d;
         frame_valid_q   <= frame_valid_d;
         frame_cmd_q     <= frame_cmd_d;
         frame_len_q     <= frame_len_d;
         frame_payload_q <= frame_payload_d;
         csum_err_q      <= csum_err_d;
         len_err_q       <= len_err_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tmo_hit) begin
         state_d = S_HDR0;
      end else if (rx_done) begin
         case (state_q)
            S_HDR0: if (rx_data == HDR0) state_d = S_HDR1;
            S_HDR1: begin
               if (rx_data == HDR1)      state_d = S_CMD;
               else if (rx_data == HDR0) state_d = S_HDR1;
               else                      state_d = S_HDR0;
            end
            S_CMD:  state_d = S_LEN;
            S_LEN: begin
               if (rx_data > LEN_MAX)    state_d = S_HDR0;
               else if (rx_data == 8'd0) state_d = S_CSUM;
               else                      state_d = S_PAY;
            end
            S_PAY:  if (idx_q == len_q - 4'd1) state_d = S_CSUM;
            S_CSUM: state_d = S_HDR0;
            default: state_d = S_HDR0;
         endcase
      end
   end

   always_comb begin
      cmd_d           = cmd_q;
      len_d           = len_q;
      sum_d           = sum_q;
      idx_d           = idx_q;
      shadow_d        = shadow_q;
      frame_cmd_d     = frame_cmd_q;
      frame_len_d     = frame_len_q;
      frame_payload_d = frame_payload_q;
      frame_valid_d   = 1'b0;
      csum_err_d      = 1'b0;
      len_err_d       = 1'b0;
      timeout_err_d   = 1'b0;

      if ((state_q == S_HDR0) || rx_done || tmo_hit) cnt_d = '0;
      else                                           cnt_d = cnt_q + 1'b1;

      if (tmo_hit) begin
         timeout_err_d = 1'b1;
      end else if (rx_done) begin
         case (state_q)
            // Clearing on entry to S_CMD leaves unused payload bytes at zero.
            S_HDR1: if (rx_data == HDR1) shadow_d = '0;
            S_CMD: begin
               cmd_d = rx_data;
               sum_d = rx_data;
            end
            S_LEN: begin
               if (rx_data > LEN_MAX) begin
                  len_err_d = 1'b1;
               end else begin
                  len_d = rx_data[3:0];
                  sum_d = sum_q + rx_data;
                  idx_d = '0;
               end
            end
            S_PAY: begin
               for (int i = 0; i < MAX_LEN; i++) begin
                  if (idx_q == 4'(i)) shadow_d[8*i +: 8] = rx_data;
               end
               sum_d = sum_q + rx_data;
               idx_d = idx_q + 4'd1;
            end
            S_CSUM: begin
               if (rx_data == sum_q) begin
                  frame_valid_d   = 1'b1;
                  frame_cmd_d     = cmd_q;
                  frame_len_d     = len_q;
                  frame_payload_d = shadow_q;
               end else begin
                  csum_err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign frame_valid   = frame_valid_q;
   assign frame_cmd     = frame_cmd_q;
   assign frame_len     = frame_len_q;
   assign frame_payload = frame_payload_q;
   assign csum_err      = csum_err_q;
   assign len_err       = len_err_q;
   assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: hand-computed frames, error cases, timeout and reset.
module tb_uart_frame_parser;

   localparam int MAX_LEN = 8;
   localparam int T       = 20;
   localparam int PW      = MAX_LEN * 8;

   logic          sys_clk = 1'b0;
   logic          rst     = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_done = 1'b0;
   logic          frame_valid;
   logic [7:0]    frame_cmd;
   logic [3:0]    frame_len;
   logic [PW-1:0] frame_payload;
   logic          csum_err;
   logic          len_err;
   logic          timeout_err;

   int errors = 0;
   int checks = 0;
   int n_valid = 0, n_csum = 0, n_len = 0, n_tmo = 0, n_overlap = 0;
   int waited;
   int snap;
   logic [7:0] seq_q[$];

   uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(T), .HDR0(8'h55), .HDR1(8'hAA)) dut (
      .sys_clk       (sys_clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_done       (rx_done),
      .frame_valid   (frame_valid),
      .frame_cmd     (frame_cmd),
      .frame_len     (frame_len),
      .frame_payload (frame_payload),
      .csum_err      (csum_err),
      .len_err       (len_err),
      .timeout_err   (timeout_err)
   );

   always #5 sys_clk = ~sys_clk;

   // Pulse counters sample the registered outputs at each rising edge.
   always @(posedge sys_clk) begin
      if (frame_valid) n_valid++;
      if (csum_err)    n_csum++;
      if (len_err)     n_len++;
      if (timeout_err) n_tmo++;
      if ($countones({frame_valid, csum_err, len_err, timeout_err}) > 1) n_overlap++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge sys_clk);
      rx_done = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic send_seq();
      foreach (seq_q[i]) send_byte(seq_q[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] cmd, input logic [3:0] len,
                              input logic [63:0] pay);
      check({tag, "_valid"}, 64'(frame_valid), 64'd1);
      check({tag, "_errs"}, 64'({csum_err, len_err, timeout_err}), 64'd0);
      check({tag, "_cmd"}, 64'(frame_cmd), 64'(cmd));
      check({tag, "_len"}, 64'(frame_len), 64'(len));
      check({tag, "_payload"}, frame_payload, pay);
   endtask

   task automatic check_err(input string tag, input logic c, input logic l, input logic t);
      check({tag, "_pulses"}, 64'({frame_valid, csum_err, len_err, timeout_err}),
            64'({1'b0, c, l, t}));
   endtask

   initial begin
      #1 rst = 1'b1;
      idle(3);
      check("rst_flags", 64'({frame_valid, csum_err, len_err, timeout_err}), 64'd0);
      check("rst_cmd_len", 64'({frame_cmd, frame_len}), 64'd0);
      check("rst_payload", frame_payload, 64'd0);
      rst = 1'b0;
      idle(2);

      seq_q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49};
      send_seq();
      check_frame("good1", 8'h01, 4'd2, 64'h3412);
      idle(1);
      check("good1_width", 64'(frame_valid), 64'd0);

      seq_q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h35, 8'h49};
      send_seq();
      check_err("badcs", 1'b1, 1'b0, 1'b0);
      check("badcs_hold_payload", frame_payload, 64'h3412);
      seq_q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h48};
      send_seq();
      check_err("badcs2", 1'b1, 1'b0, 1'b0);
      check("badcs2_hold", 64'({frame_cmd, frame_len}), 64'h012);
      seq_q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49};
      send_seq();
      check_frame("good2", 8'h01, 4'd2, 64'h3412);

      seq_q = '{8'h55, 8'hAA, 8'h07, 8'h09};
      send_seq();
      check_err("len9", 1'b0, 1'b1, 1'b0);
      seq_q = '{8'h55, 8'hAA, 8'hFF, 8'h01, 8'h02, 8'h02};
      send_seq();
      check_frame("wrap", 8'hFF, 4'd1, 64'h02);

      seq_q = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h05, 8'h00, 8'h05};
      send_seq();
      check_frame("resync_len0", 8'h05, 4'd0, 64'h0);

      seq_q = '{8'h55, 8'hAA, 8'h09, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h35};
      send_seq();
      check_frame("maxlen", 8'h09, 4'd8, 64'h0807060504030201);

      seq_q = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h10, 8'h13};
      send_seq();
      check_frame("b2b_a", 8'h02, 4'd1, 64'h10);
      seq_q = '{8'h55, 8'hAA, 8'h04, 8'h00, 8'h04};
      send_seq();
      check_frame("b2b_b", 8'h04, 4'd0, 64'h0);

      seq_q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12};
      send_seq();
      waited = 0;
      while (!timeout_err && waited < T + 5) begin
         @(negedge sys_clk);
         waited++;
      end
      check("timeout_latency", 64'(waited), 64'(T));
      check_err("timeout", 1'b0, 1'b0, 1'b1);
      seq_q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49};
      send_seq();
      check_frame("after_tmo", 8'h01, 4'd2, 64'h3412);

      seq_q = '{8'h55, 8'hAA, 8'h06, 8'h02, 8'h12};
      send_seq();
      idle(T - 1);
      send_byte(8'h34);
      check("coincide_no_tmo", 64'(timeout_err), 64'd0);
      send_byte(8'h4E);
      check_frame("coincide", 8'h06, 4'd2, 64'h3412);

      seq_q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12};
      send_seq();
      snap = n_valid + n_csum + n_len + n_tmo;
      rst = 1'b1;
      #1;
      check("midrst_flags", 64'({frame_valid, csum_err, len_err, timeout_err}), 64'd0);
      check("midrst_cmd_len", 64'({frame_cmd, frame_len}), 64'd0);
      check("midrst_payload", frame_payload, 64'd0);
      idle(2);
      rst = 1'b0;
      idle(2);
      send_byte(8'h34);
      send_byte(8'h49);
      idle(2);
      check("midrst_no_pulse", 64'(n_valid + n_csum + n_len + n_tmo), 64'(snap));
      seq_q = '{8'h55, 8'hAA, 8'h03, 8'h01, 8'h7E, 8'h82};
      send_seq();
      check_frame("post_rst", 8'h03, 4'd1, 64'h7E);

      idle(3);
      check("count_valid", 64'(n_valid), 64'd10);
      check("count_csum", 64'(n_csum), 64'd2);
      check("count_len", 64'(n_len), 64'd1);
      check("count_tmo", 64'(n_tmo), 64'd1);
      check("count_overlap", 64'(n_overlap), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
